// File: rtl/misty1_host_drv_if.sv
// Host/core handshake bundle for misty1_host_drv: request/result port plus
// the MISTY1 core load/busy handshake. The driver uses the slave view.
interface misty1_host_drv_if;
  logic         req_valid, req_ready, req_key_load, req_en_de;
  logic [127:0] req_key;
  logic [63:0]  req_data;
  logic         res_valid, res_ready, res_err;
  logic [63:0]  res_data;
  logic         core_key_rdy, core_data_rdy, core_en_de;
  logic [127:0] core_key_in;
  logic [63:0]  core_data_in, core_data_out;
  logic         core_data_valid, core_key_valid, core_busy;

  modport slave (
    input  req_valid, req_key_load, req_en_de, req_key, req_data, res_ready,
           core_data_out, core_data_valid, core_key_valid, core_busy,
    output req_ready, res_valid, res_data, res_err,
           core_key_rdy, core_data_rdy, core_en_de, core_key_in, core_data_in
  );

  modport master (
    output req_valid, req_key_load, req_en_de, req_key, req_data, res_ready,
           core_data_out, core_data_valid, core_key_valid, core_busy,
    input  req_ready, res_valid, res_data, res_err,
           core_key_rdy, core_data_rdy, core_en_de, core_key_in, core_data_in
  );
endinterface

// File: rtl/misty1_host_drv.sv
// Host-side sequencer for the MISTY1 core: key schedule load, data load, result capture.
// Optional MISTY1_DRV_KEYCACHE_EN skips the key schedule when the requested key is already loaded.
module misty1_host_drv #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic              clk,
  input logic              reset,
  misty1_host_drv_if.slave bus
);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, KEY_ISSUE, KEY_WAIT, DATA_ISSUE, DATA_WAIT, RESP} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_q;
  logic [63:0]  data_q, res_data_q;
  logic         en_de_q, res_err_q, key_loaded;
  logic [15:0]  cnt;
  logic         accept, key_pulse, data_pulse, key_done, data_done, tmo;
  logic         cache_hit, guard, cnt_last, in_wait;

`ifdef MISTY1_DRV_KEYCACHE_EN
  logic [127:0] key_cache;
  always_ff @(posedge clk or posedge reset)
    if (reset)         key_cache <= '0;
    else if (key_done) key_cache <= key_q;
  assign cache_hit = key_loaded && (bus.req_key == key_cache);
`else
  assign cache_hit = 1'b0;
`endif

  // cnt is 0 in the first cycle of each wait state; that cycle ignores core valids
  assign guard    = (cnt == 16'd0);
  assign cnt_last = ((cnt + 16'd1) == TO_LIM);
  assign in_wait  = (state == KEY_WAIT) || (state == DATA_WAIT);

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    key_pulse  = 1'b0;
    data_pulse = 1'b0;
    key_done   = 1'b0;
    data_done  = 1'b0;
    tmo        = 1'b0;
    unique case (state)
      IDLE: if (bus.req_valid) begin
        accept = 1'b1;
        if (bus.req_key_load && !cache_hit) state_nxt = KEY_ISSUE;
        else if (key_loaded)                state_nxt = DATA_ISSUE;
        else                                state_nxt = RESP;
      end
      KEY_ISSUE: if (!bus.core_busy) begin
        key_pulse = 1'b1;
        state_nxt = KEY_WAIT;
      end
      KEY_WAIT: if (!guard && bus.core_key_valid) begin
        key_done  = 1'b1;
        state_nxt = DATA_ISSUE;
      end else if (cnt_last) begin
        tmo       = 1'b1;
        state_nxt = RESP;
      end
      DATA_ISSUE: if (!bus.core_busy) begin
        data_pulse = 1'b1;
        state_nxt  = DATA_WAIT;
      end
      DATA_WAIT: if (!guard && bus.core_data_valid) begin
        data_done = 1'b1;
        state_nxt = RESP;
      end else if (cnt_last) begin
        tmo       = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      key_q      <= '0;
      data_q     <= '0;
      en_de_q    <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      key_loaded <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (in_wait && state_nxt == state) ? cnt + 16'd1 : 16'd0;
      // result fields start cleared so error paths report res_data = 0
      if (accept) begin
        key_q      <= bus.req_key;
        data_q     <= bus.req_data;
        en_de_q    <= bus.req_en_de;
        res_data_q <= '0;
        res_err_q  <= (state_nxt == RESP);
      end
      if (key_pulse) key_loaded <= 1'b0;
      if (key_done)  key_loaded <= 1'b1;
      if (data_done) res_data_q <= bus.core_data_out;
      if (tmo)       res_err_q  <= 1'b1;
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.res_valid     = (state == RESP);
  assign bus.res_data      = res_data_q;
  assign bus.res_err       = res_err_q;
  assign bus.core_key_rdy  = key_pulse;
  assign bus.core_data_rdy = data_pulse;
  assign bus.core_en_de    = en_de_q;
  assign bus.core_key_in   = key_q;
  assign bus.core_data_in  = data_q;
endmodule

// File: doc/misty1_host_drv.md
Name: misty1_host_drv

Overview:
Synthesizable host-side driver for the MISTY1 one-round/three-clock core. It is the initiator end of the core's key_rdy/data_rdy/key_valid/data_valid/busy handshake.
- Accepts encrypt/decrypt requests on a valid/ready port.
- Sequences the key-schedule load, then the data load, into the core, and returns the captured result on a back-pressured result port.
- Replaces the hand-timed pulse sequencing used in benches with a reusable RTL front end.

Parameters:
TIMEOUT_CYC, 255, max cycles waited in KEY_WAIT or DATA_WAIT before aborting with error (1..65535)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at rising edge
req_key_load  in  1  1: run key schedule with req_key before data
req_en_de  in  1  0 encrypt, 1 decrypt
req_key  in  128  key
req_data  in  64  plaintext/ciphertext
res_valid  out  1  result present
res_ready  in  1  result consumed when res_valid & res_ready
res_data  out  64  core output (0 on error)
res_err  out  1  1: timeout or no key loaded
core_key_rdy  out  1  one-cycle key load pulse to core
core_data_rdy  out  1  one-cycle data start pulse to core
core_en_de  out  1  direction to core, held from issue until result capture
core_key_in  out  128  key to core, registered
core_data_in  out  64  data to core, registered
core_data_out  in  64  core result
core_data_valid  in  1  core result valid
core_key_valid  in  1  core key schedule complete
core_busy  in  1  core busy

Behaviour:
- Reset (async, immediate): state IDLE; key_loaded=0; timeout counter=0.
  - All outputs 0, except req_ready=1 once IDLE is entered.
  - Reset mid-operation abandons the transaction; no result is emitted.
- States: IDLE, KEY_ISSUE, KEY_WAIT, DATA_ISSUE, DATA_WAIT, RESP.
- IDLE: req_ready=1. On accept:
  - Register key, data and en_de.
  - If req_key_load=1, go to KEY_ISSUE.
  - Else if key_loaded=1, go to DATA_ISSUE.
  - Else go to RESP with res_err=1, res_data=0 (no core activity).
- KEY_ISSUE: waits while core_busy=1. When core_busy=0, asserts core_key_rdy for exactly one cycle, clears key_loaded, goes to KEY_WAIT.
- KEY_WAIT: the first cycle after the pulse is a guard cycle, and core_key_valid is ignored in it. Thereafter:
  - core_key_valid=1: set key_loaded=1, go to DATA_ISSUE.
  - Counter reaches TIMEOUT_CYC: go to RESP with err=1.
- DATA_ISSUE: same busy rule as KEY_ISSUE. core_data_rdy is pulsed for one cycle, then go to DATA_WAIT.
- DATA_WAIT: one guard cycle, then capture core_data_out on the first cycle core_data_valid=1 and go to RESP with err=0. On timeout, go to RESP with err=1 and res_data=0.
- RESP: res_valid=1 with res_data/res_err stable until res_ready=1. Then return to IDLE.
  - req_ready is 0 in RESP, so no overlap between transactions.
  - Minimum request-to-request spacing is therefore the full transaction.
- Timeout counter: cleared on entry to each WAIT state and increments every WAIT cycle, guard cycle included.
- core_key_rdy and core_data_rdy are never high simultaneously. Neither is ever high for more than one cycle.
- core_key_in and core_data_in change only in IDLE on accept.
- A timeout during KEY_WAIT leaves key_loaded=0.
- Latency from accept to res_valid, with the core idle:
  - key path: 1 (issue) + key schedule + 1 (data issue) + encryption + 1 (capture).
  - data-only path: 1 (issue) + encryption + 1 (capture).

Optional Feature:
MISTY1_DRV_KEYCACHE_EN
- Defined: a 128-bit copy of the last successfully scheduled key is kept. A request with req_key_load=1 whose key equals the stored copy, with key_loaded=1, skips KEY_ISSUE/KEY_WAIT and goes straight to DATA_ISSUE.
- Not defined: no stored copy and no comparator. req_key_load=1 always reruns the key schedule.

Test Plan:
- Encrypt with key load: key 00112233445566778899aabbccddeeff, data 0123456789abcdef, en_de=0 -> exactly one core_key_rdy pulse, then one core_data_rdy pulse; res_data=8b1da5f56ab3d07c, res_err=0.
- Decrypt, no key load: next request key_load=0, en_de=1, data 8b1da5f56ab3d07c -> no core_key_rdy pulse; res_data=0123456789abcdef, res_err=0.
- No key loaded: request with key_load=0 directly after reset -> res_valid with res_err=1, res_data=0; core_key_rdy and core_data_rdy stay 0.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid -> res_data stable, req_ready=0 throughout; accept completes on the cycle res_ready=1.
- Timeout: core model never asserts core_data_valid, TIMEOUT_CYC=16 -> res_err=1 exactly 16 cycles after the DATA_WAIT entry; reset asserted mid-KEY_WAIT -> outputs 0 immediately, key_loaded=0.
- MISTY1_DRV_KEYCACHE_EN: repeat the first scenario with the same key and key_load=1 -> with macro, no core_key_rdy pulse and same result; without macro, one core_key_rdy pulse.
